// File: rtl/run_seq_pkg.sv
// Shared types and default parameters for the run sequencer: FSM state encoding
// and the default launch/watchdog timing.
package run_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RST_CORE,
        RUN,
        FINISH
    } run_state_t;

    localparam int DEF_RST_CYCLES     = 2;
    localparam int DEF_TIMEOUT_CYCLES = 4095;
    localparam int DEF_CNT_W          = 16;

endpackage

// File: rtl/run_sequencer_if.sv
// Requester/core-facing signal bundle of the run sequencer.
// The master side is the host plus core; the slave side is the sequencer itself.
interface run_sequencer_if
    import run_seq_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) ();

    logic             req;
    logic             core_done;
    logic             core_reset;
    logic             busy;
    logic             ack;
    logic             timed_out;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output req, core_done,
        input  core_reset, busy, ack, timed_out, cycle_count
    );

    modport slave (
        input  req, core_done,
        output core_reset, busy, ack, timed_out, cycle_count
    );

endinterface

// File: rtl/run_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over enable.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    // NOTE: sequential state is written with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/run_sequencer.sv
// Launch/supervise stage for the accumulator core: pulses the core reset on a
// request edge, lets it run, and reports completion or watchdog abort.
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int RST_CYCLES     = DEF_RST_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic            clk,
    input  logic            reset,
    run_sequencer_if.slave  bus
);

    localparam int RCW = $clog2(RST_CYCLES + 1);

    run_state_t       state, state_d;
    logic [RCW-1:0]   rst_cnt, rst_cnt_d;
    logic             req_q;
    logic             core_reset_q, core_reset_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic             timed_out_q, timed_out_d;
    logic             cnt_clear, cnt_en;
    logic [CNT_W-1:0] cycle_count;
    logic             launch;
    logic             timeout_hit;

    assign launch      = bus.req & ~req_q;
    assign timeout_hit = (cycle_count == CNT_W'(TIMEOUT_CYCLES - 1));

    sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk    (clk),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .count  (cycle_count)
    );

    // NOTE: every signal gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d      = state;
        rst_cnt_d    = rst_cnt;
        core_reset_d = core_reset_q;
        busy_d       = busy_q;
        ack_d        = 1'b0;
        timed_out_d  = timed_out_q;
        cnt_clear    = 1'b0;
        cnt_en       = 1'b0;

        case (state)
            IDLE: begin
                core_reset_d = 1'b1;
                busy_d       = 1'b0;
                if (launch) begin
                    state_d     = RST_CORE;
                    busy_d      = 1'b1;
                    timed_out_d = 1'b0;
                    cnt_clear   = 1'b1;
                    rst_cnt_d   = '0;
                end
            end
            RST_CORE: begin
                if (rst_cnt == RCW'(RST_CYCLES)) begin
                    state_d      = RUN;
                    core_reset_d = 1'b0;
                end else begin
                    rst_cnt_d = rst_cnt + RCW'(1);
                end
            end
            RUN: begin
                cnt_en = 1'b1;
                // A done seen on the watchdog's final cycle still counts as a clean finish.
                if (bus.core_done) begin
                    state_d      = FINISH;
                    ack_d        = 1'b1;
                    core_reset_d = 1'b1;
                end else if (timeout_hit) begin
                    state_d      = FINISH;
                    ack_d        = 1'b1;
                    core_reset_d = 1'b1;
                    timed_out_d  = 1'b1;
                end
            end
            FINISH: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            rst_cnt      <= '0;
            req_q        <= 1'b0;
            core_reset_q <= 1'b1;
            busy_q       <= 1'b0;
            ack_q        <= 1'b0;
            timed_out_q  <= 1'b0;
        end else begin
            state        <= state_d;
            rst_cnt      <= rst_cnt_d;
            req_q        <= bus.req;
            core_reset_q <= core_reset_d;
            busy_q       <= busy_d;
            ack_q        <= ack_d;
            timed_out_q  <= timed_out_d;
        end
    end

    assign bus.core_reset  = core_reset_q;
    assign bus.busy        = busy_q;
    assign bus.ack         = ack_q;
    assign bus.timed_out   = timed_out_q;
    assign bus.cycle_count = cycle_count;

endmodule
